apb_master_arbiter: RTL and testbench

Synthesizable APB3 master that shares one APB bus between NUM_REQ local requesters. Each requester issues single read/write commands over a valid/ready request channel and receives a one-cycle response pulse. The block arbitrates round-robin, sequences the APB IDLE/SETUP/ACCESS phases, and drives the PSELx/PENABLE/PWRITE/PADDR/PWDATA signals that the APB interface and testbench monitor observe.

---
 rtl/apb_master_arbiter_if.sv | 39 +++
 rtl/apb_master_arbiter.sv | 162 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_arbiter_if : requester command/response channels + APB3 signals |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_arbiter : round-robin APB3 master shared by NUM_REQ requesters. |
// | Optional ACCESS timeout enabled by macro APB_ARB_TIMEOUT_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module apb_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic            PCLK,
    input  wire logic            PRESETn,
    apb_master_arbiter_if.master bus
);
    localparam int                   c_IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [c_IDX_W-1:0]   c_LAST  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_ONE   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_grant;
    logic                 w_done;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [31:0]          r_paddr;
    logic [31:0]          r_pwdata;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;

    // First valid requester found walking upward from the one after last_grant.
    function automatic logic [c_IDX_W-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                                     input logic [c_IDX_W-1:0] last);
        logic [c_IDX_W-1:0] idx;
        logic [c_IDX_W-1:0] pick;
        logic               found;
        idx   = last;
        pick  = last;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == c_LAST) ? '0 : idx + 1'b1;
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb w_pick = f_rr_pick(bus.req_valid, r_last_grant);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_to_cnt <= '0;
        end else if (w_grant) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ACCESS && !bus.PREADY) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Abort on the wait cycle that brings the count to the limit; PREADY=1 wins.
    assign w_timeout = (r_state == S_ACCESS) && !bus.PREADY &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is gated by PRESETn so req_ready stays low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_ready     = '0;
        case (r_state)
            S_IDLE: begin
                if (PRESETn && |bus.req_valid) begin
                    w_grant     = 1'b1;
                    w_ready     = c_ONE << w_pick;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.PREADY || w_timeout) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last_grant <= c_LAST;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_grant) begin
                r_last_grant <= w_pick;
                r_psel       <= 1'b1;
                r_penable    <= 1'b0;
                r_pwrite     <= bus.req_write[w_pick];
                r_paddr      <= bus.req_addr[32*w_pick +: 32];
                r_pwdata     <= bus.req_write[w_pick] ? bus.req_wdata[32*w_pick +: 32] : 32'h0;
            end
            if (r_state == S_SETUP) begin
                r_penable <= 1'b1;
            end
            if (w_done) begin
                r_psel      <= 1'b0;
                r_penable   <= 1'b0;
                r_rsp_valid <= c_ONE << r_last_grant;
                r_rsp_rdata <= (w_timeout || r_pwrite) ? 32'h0 : bus.PRDATA;
                r_rsp_err   <= w_timeout | bus.PSLVERR;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.PSELx     = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_master_arbiter : directed vector bench for apb_master_arbiter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_apb_master_arbiter;
    logic PCLK;
    logic PRESETn;
    int   n_checks;
    int   n_errors;

    apb_master_arbiter_if #(.NUM_REQ(2)) bus ();

    apb_master_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input vec_t v);
        logic [1:0]  oh;
        logic [31:0] exp_wd;
        int          n;
        oh     = 2'b01 << v.id;
        exp_wd = v.wr ? v.wdata : 32'h0;
        @(negedge PCLK);
        bus.req_addr  = 64'hFFFF_0000_FFFF_0000;
        bus.req_wdata = 64'h5555_AAAA_5555_AAAA;
        bus.req_write = {2{~v.wr}};
        bus.req_addr[32*v.id +: 32]  = v.addr;
        bus.req_wdata[32*v.id +: 32] = v.wdata;
        bus.req_write[v.id]          = v.wr;
        bus.req_valid = oh;
        #1;
        chk("req_ready", bus.req_ready, oh);
        chk("busy_idle", bus.busy, 0);
        @(posedge PCLK); #1;
        bus.req_valid = '0;
        chk("setup_sel_en", {bus.PSELx, bus.PENABLE}, 2'b10);
        chk("setup_paddr", bus.PADDR, v.addr);
        chk("setup_pwdata", bus.PWDATA, exp_wd);
        chk("setup_pwrite", bus.PWRITE, v.wr);
        chk("setup_ready", bus.req_ready, 0);
        chk("setup_busy", bus.busy, 1);
        @(posedge PCLK); #1;
        chk("access_sel_en", {bus.PSELx, bus.PENABLE}, 2'b11);
        n = 0;
        while (1) begin
            bus.PREADY  = (n == v.waits);
            bus.PSLVERR = (n == v.waits) ? v.slverr : 1'b1;
            bus.PRDATA  = (n == v.waits) ? v.prdata : 32'hBADD_A7A0;
            @(posedge PCLK); #1;
            if (n == v.waits) break;
            n++;
            chk("wait_hold", {bus.PSELx, bus.PENABLE, bus.rsp_valid}, 4'b1100);
            chk("wait_paddr", bus.PADDR, v.addr);
            chk("wait_pwdata", bus.PWDATA, exp_wd);
        end
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        chk("rsp_err", bus.rsp_err, v.exp_err);
        chk("done_sel_en", {bus.PSELx, bus.PENABLE, bus.busy}, 3'b000);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h0;
        @(posedge PCLK); #1;
        chk("rsp_pulse_end", bus.rsp_valid, 0);
    endtask

    initial begin
        int gid[4];
        int gcyc[4];
        int gcnt;
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_0020, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2] = '{0, 1'b1, 32'h0000_0030, 32'h0000_A5A5, 0, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1};
        vecs[3] = '{1, 1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[4] = '{0, 1'b0, 32'h0000_0044, 32'h7777_7777, 2, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
        vecs[5] = '{1, 1'b0, 32'h0000_0048, 32'h0,         0, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0};

        PRESETn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_apb", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.busy}, 4'b0000);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.req_ready}, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

        // Fairness: both requesters held valid, completer always ready.
        @(negedge PCLK);
        bus.PREADY    = 1'b1;
        bus.req_write = 2'b00;
        bus.req_valid = 2'b11;
        gcnt = 0;
        for (int c = 0; c < 40 && gcnt < 4; c++) begin
            if (c > 0) @(negedge PCLK);
            #1;
            if (bus.req_ready != 2'b00) begin
                gid[gcnt]  = (bus.req_ready == 2'b10) ? 1 : 0;
                gcyc[gcnt] = c;
                gcnt++;
            end
        end
        @(posedge PCLK); #1;
        bus.req_valid = 2'b00;
        repeat (3) @(posedge PCLK);
        #1;
        bus.PREADY = 1'b0;
        chk("fair_count", gcnt, 4);
        if (gcnt == 4) begin
            for (int g = 0; g < 4; g++) chk("fair_order", gid[g], g % 2);
            for (int g = 1; g < 4; g++) chk("fair_spacing", gcyc[g] - gcyc[g-1], 3);
        end

        // Reset in the middle of a waited ACCESS phase.
        @(negedge PCLK);
        bus.req_write = 2'b01;
        bus.req_addr  = 64'h0000_0000_0000_0050;
        bus.req_wdata = 64'h0000_0000_1111_2222;
        bus.req_valid = 2'b01;
        @(posedge PCLK); #1;
        bus.req_valid = 2'b00;
        repeat (3) @(posedge PCLK);
        #3;
        chk("pre_rst_access", {bus.PSELx, bus.PENABLE}, 2'b11);
        bus.req_valid = 2'b11;
        PRESETn = 1'b0;
        #1;
        chk("arst_apb", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.busy}, 4'b0000);
        chk("arst_paddr", bus.PADDR, 0);
        chk("arst_pwdata", bus.PWDATA, 0);
        chk("arst_rsp_ready", {bus.rsp_valid, bus.req_ready}, 0);
        bus.req_valid = 2'b00;
        bus.PREADY    = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        chk("post_rst_no_rsp", {bus.rsp_valid, bus.busy}, 0);
        @(negedge PCLK);
        bus.req_addr  = 64'h0000_0064_0000_0060;
        bus.req_write = 2'b00;
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_first", bus.req_ready, 2'b01);
        @(posedge PCLK); #1;
        bus.req_valid = 2'b00;
        chk("post_rst_paddr", bus.PADDR, 32'h60);
        repeat (2) @(posedge PCLK);
        #1;
        chk("post_rst_rsp", bus.rsp_valid, 2'b01);
        bus.PREADY = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
        begin
            int waits;
            logic seen;
            @(negedge PCLK);
            bus.req_write = 2'b10;
            bus.req_valid = 2'b10;
            @(posedge PCLK); #1;
            bus.req_valid = 2'b00;
            @(posedge PCLK); #1;
            waits = 0;
            seen  = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                bus.PRDATA = 32'hFEED_0000;
                @(posedge PCLK); #1;
                waits++;
                seen = (bus.rsp_valid != 2'b00);
            end
            chk("to_seen", seen, 1);
            chk("to_waits", waits, 16);
            chk("to_rsp_valid", bus.rsp_valid, 2'b10);
            chk("to_err", bus.rsp_err, 1);
            chk("to_rdata", bus.rsp_rdata, 0);
            chk("to_psel", {bus.PSELx, bus.PENABLE}, 2'b00);
        end
`endif

        repeat (2) @(posedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
